// File: rtl/sc_speedtick_controller_if.sv
// Counter-side bus of the speed-tick controller:
// counter value in, active-low upcount/clear out.
interface sc_speedtick_controller_if #(
    parameter int DATAWIDTH = 23
);
    logic [DATAWIDTH-1:0] SC_SPEEDTICK_count_InBUS;
    logic                 SC_SPEEDTICK_upcount_OutLow;
    logic                 SC_SPEEDTICK_clear_OutLow;

    modport master (
        input  SC_SPEEDTICK_count_InBUS,
        output SC_SPEEDTICK_upcount_OutLow,
        output SC_SPEEDTICK_clear_OutLow
    );

    modport slave (
        output SC_SPEEDTICK_count_InBUS,
        input  SC_SPEEDTICK_upcount_OutLow,
        input  SC_SPEEDTICK_clear_OutLow
    );
endinterface

// File: rtl/sc_speedtick_controller.sv
// Programmable-period pace generator driving a free-running
// counter; emits one tick every BASE_LIMIT>>level cycles.
module sc_speedtick_controller #(
    parameter int DATAWIDTH   = 23,
    parameter int LEVEL_WIDTH = 3,
    parameter int BASE_LIMIT  = 4000000
) (
    input  logic                   SC_SPEEDTICK_CLOCK_50,
    input  logic                   SC_SPEEDTICK_RESET_InLow,
    input  logic                   SC_SPEEDTICK_start_InLow,
    input  logic                   SC_SPEEDTICK_pause_InLow,
    input  logic                   SC_SPEEDTICK_stop_InLow,
    input  logic                   SC_SPEEDTICK_levelup_InLow,
    sc_speedtick_controller_if.master cnt_bus,
    output logic                   SC_SPEEDTICK_tick_OutHigh,
    output logic [LEVEL_WIDTH-1:0] SC_SPEEDTICK_level_OutBUS,
    output logic                   SC_SPEEDTICK_running_OutHigh
);
    localparam int MAX_LEVEL = (1 << LEVEL_WIDTH) - 1;
    localparam logic [DATAWIDTH-1:0] BASE = DATAWIDTH'(BASE_LIMIT);
    localparam logic [LEVEL_WIDTH-1:0] LVL_MAX = LEVEL_WIDTH'(MAX_LEVEL);

    // Shortest period must still be at least two cycles, and the
    // base period must be representable on the counter bus.
    if (!(((BASE_LIMIT >> MAX_LEVEL) >= 2) &&
          (longint'(BASE_LIMIT) < (64'd1 << DATAWIDTH)))) begin : g_bad_cfg
        $error("sc_speedtick_controller: bad BASE_LIMIT");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_t;

    state_t                 state_q, state_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   tick_q, tick_d;
    logic                   lvl_q;

    logic [DATAWIDTH-1:0]   limit;
    logic [DATAWIDTH-1:0]   limit_m1;
    logic                   terminal;
    logic                   lvl_fall;
    logic                   stop_n;

    assign stop_n   = SC_SPEEDTICK_stop_InLow;
    assign limit    = BASE >> level_q;
    assign limit_m1 = limit - DATAWIDTH'(1);
    // >= so a shortened period never lets the counter overrun
    assign terminal = (cnt_bus.SC_SPEEDTICK_count_InBUS >= limit_m1);
    assign lvl_fall = lvl_q & ~SC_SPEEDTICK_levelup_InLow;

    // Registered state, tick, level and levelup edge history
    always_ff @(posedge SC_SPEEDTICK_CLOCK_50) begin
        if (!SC_SPEEDTICK_RESET_InLow) begin
            state_q <= S_IDLE;
            level_q <= '0;
            tick_q  <= 1'b0;
            lvl_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            tick_q  <= tick_d;
            lvl_q   <= SC_SPEEDTICK_levelup_InLow;
        end
    end

    // Sequencing FSM and counter drive; upcount and clear never both low
    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        cnt_bus.SC_SPEEDTICK_upcount_OutLow = 1'b1;
        cnt_bus.SC_SPEEDTICK_clear_OutLow   = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                cnt_bus.SC_SPEEDTICK_clear_OutLow = 1'b0;
                if (stop_n && !SC_SPEEDTICK_start_InLow)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (!stop_n)
                    state_d = S_IDLE;
                else if (!SC_SPEEDTICK_pause_InLow)
                    state_d = S_PAUSE;
                if (terminal || !stop_n)
                    cnt_bus.SC_SPEEDTICK_clear_OutLow = 1'b0;
                else
                    cnt_bus.SC_SPEEDTICK_upcount_OutLow = 1'b0;
                tick_d = terminal & stop_n;
            end
            S_PAUSE: begin
                if (!stop_n) begin
                    state_d = S_IDLE;
                    cnt_bus.SC_SPEEDTICK_clear_OutLow = 1'b0;
                end else if (SC_SPEEDTICK_pause_InLow) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_bus.SC_SPEEDTICK_clear_OutLow = 1'b0;
            end
        endcase
    end

    // Level: stop clears, levelup edge outside IDLE saturates upward
    always_comb begin
        level_d = level_q;
        if (!stop_n)
            level_d = '0;
        else if (lvl_fall && (state_q != S_IDLE) && (level_q != LVL_MAX))
            level_d = level_q + LEVEL_WIDTH'(1);
    end

    assign SC_SPEEDTICK_tick_OutHigh    = tick_q;
    assign SC_SPEEDTICK_level_OutBUS    = level_q;
    assign SC_SPEEDTICK_running_OutHigh = (state_q != S_IDLE);
endmodule

// File: tb/tb_sc_speedtick_controller.sv
// Bench for sc_speedtick_controller with a behavioural counter;
// tick times go into a queue checked by a separate monitor.
module tb_sc_speedtick_controller;
    logic        clk;
    logic        rst_n;
    logic        start_n;
    logic        pause_n;
    logic        stop_n;
    logic        lvl_n;
    logic        tick;
    logic [1:0]  level;
    logic        running;
    logic [22:0] cnt;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int maxc = 0;
    int exp_q[$];
    int s;

    sc_speedtick_controller_if #(.DATAWIDTH(23)) bus();

    sc_speedtick_controller #(
        .DATAWIDTH(23),
        .LEVEL_WIDTH(2),
        .BASE_LIMIT(16)
    ) dut (
        .SC_SPEEDTICK_CLOCK_50(clk),
        .SC_SPEEDTICK_RESET_InLow(rst_n),
        .SC_SPEEDTICK_start_InLow(start_n),
        .SC_SPEEDTICK_pause_InLow(pause_n),
        .SC_SPEEDTICK_stop_InLow(stop_n),
        .SC_SPEEDTICK_levelup_InLow(lvl_n),
        .cnt_bus(bus),
        .SC_SPEEDTICK_tick_OutHigh(tick),
        .SC_SPEEDTICK_level_OutBUS(level),
        .SC_SPEEDTICK_running_OutHigh(running)
    );

    assign bus.SC_SPEEDTICK_count_InBUS = cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // counter: reset high = ~rst_n, upcount has priority over clear
    always @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (!bus.SC_SPEEDTICK_upcount_OutLow)
            cnt <= cnt + 23'd1;
        else if (!bus.SC_SPEEDTICK_clear_OutLow)
            cnt <= '0;
    end

    // monitor: pops expected tick cycles whenever a tick appears
    always begin
        @(posedge clk);
        #1;
        if (int'(cnt) > maxc) maxc = int'(cnt);
        while (exp_q.size() > 0 && exp_q[0] < cyc) begin
            total++;
            bad++;
            $display("FAIL tick_missing got=no_tick want_cycle=%0d", exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (tick) begin
            total++;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                void'(exp_q.pop_front());
            end else begin
                bad++;
                $display("FAIL tick_unexpected got_cycle=%0d want_cycle=%0d",
                         cyc, (exp_q.size() > 0) ? exp_q[0] : -1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_n = 1'b1;
        pause_n = 1'b1;
        stop_n = 1'b1;
        lvl_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(output int st);
        start_n = 1'b0;
        st = cyc + 1;
        @(negedge clk);
        start_n = 1'b1;
    endtask

    task automatic pulse_lvl();
        lvl_n = 1'b0;
        @(negedge clk);
        lvl_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start_n = 1'b1;
        pause_n = 1'b1;
        stop_n = 1'b1;
        lvl_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_running", int'(running), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_clear", int'(bus.SC_SPEEDTICK_clear_OutLow), 0);
        chk("rst_upcount", int'(bus.SC_SPEEDTICK_upcount_OutLow), 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_running", int'(running), 0);
        chk("idle_count", int'(cnt), 0);

        // basic 16-cycle period
        maxc = 0;
        do_start(s);
        chk("a_running", int'(running), 1);
        for (int k = 1; k <= 4; k++) exp_q.push_back(s + 16 * k);
        wait_until(s + 70);
        chk("a_maxcount", maxc, 15);
        chk("a_level", int'(level), 0);

        // three levelups 40 cycles apart, then a saturating fourth
        do_reset();
        do_start(s);
        exp_q.push_back(s + 16);
        exp_q.push_back(s + 32);
        for (int t = 41; t <= 73; t += 8) exp_q.push_back(s + t);
        for (int t = 81; t <= 117; t += 4) exp_q.push_back(s + t);
        for (int t = 121; t <= 169; t += 2) exp_q.push_back(s + t);
        wait_until(s + 39);
        pulse_lvl();
        chk("b_level1", int'(level), 1);
        chk("b_count1", int'(cnt), 8);
        wait_until(s + 79);
        pulse_lvl();
        chk("b_level2", int'(level), 2);
        chk("b_count2", int'(cnt), 7);
        wait_until(s + 119);
        pulse_lvl();
        chk("b_level3", int'(level), 3);
        chk("b_count3", int'(cnt), 3);
        wait_until(s + 159);
        pulse_lvl();
        chk("b_level_sat", int'(level), 3);
        wait_until(s + 170);
        // reset with a tick pending: it must be dropped
        rst_n = 1'b0;
        @(negedge clk);
        chk("b_rst_tick", int'(tick), 0);
        chk("b_rst_level", int'(level), 0);
        chk("b_rst_running", int'(running), 0);
        rst_n = 1'b1;

        // levelup at count 12 forces an immediate tick
        do_reset();
        do_start(s);
        exp_q.push_back(s + 14);
        exp_q.push_back(s + 22);
        exp_q.push_back(s + 30);
        exp_q.push_back(s + 38);
        wait_until(s + 12);
        chk("c_count12", int'(cnt), 12);
        pulse_lvl();
        chk("c_level", int'(level), 1);
        @(negedge clk);
        chk("c_cleared", int'(cnt), 0);
        wait_until(s + 40);

        // pause at count 5 for 20 cycles
        do_reset();
        do_start(s);
        exp_q.push_back(s + 36);
        exp_q.push_back(s + 52);
        wait_until(s + 4);
        pause_n = 1'b0;
        wait_until(s + 5);
        chk("d_count5", int'(cnt), 5);
        wait_until(s + 15);
        chk("d_hold", int'(cnt), 5);
        chk("d_running", int'(running), 1);
        chk("d_upcount", int'(bus.SC_SPEEDTICK_upcount_OutLow), 1);
        chk("d_clear", int'(bus.SC_SPEEDTICK_clear_OutLow), 1);
        wait_until(s + 24);
        chk("d_hold_end", int'(cnt), 5);
        pause_n = 1'b1;
        wait_until(s + 55);

        // stop on the terminal cycle
        do_reset();
        do_start(s);
        exp_q.push_back(s + 8);
        wait_until(s + 2);
        pulse_lvl();
        chk("e_level1", int'(level), 1);
        wait_until(s + 15);
        chk("e_count7", int'(cnt), 7);
        stop_n = 1'b0;
        #1;
        chk("e_clear", int'(bus.SC_SPEEDTICK_clear_OutLow), 0);
        chk("e_upcount", int'(bus.SC_SPEEDTICK_upcount_OutLow), 1);
        @(negedge clk);
        stop_n = 1'b1;
        chk("e_running", int'(running), 0);
        chk("e_level0", int'(level), 0);
        chk("e_count0", int'(cnt), 0);
        pulse_lvl();
        @(negedge clk);
        pulse_lvl();
        @(negedge clk);
        chk("e_idle_lvl", int'(level), 0);
        wait_until(s + 25);

        // start and pause together in IDLE: one RUN cycle then hold
        do_reset();
        start_n = 1'b0;
        pause_n = 1'b0;
        s = cyc + 1;
        @(negedge clk);
        start_n = 1'b1;
        chk("g_running", int'(running), 1);
        wait_until(s + 3);
        chk("g_count1", int'(cnt), 1);
        pause_n = 1'b1;

        // reset mid-RUN at count 9
        do_reset();
        do_start(s);
        wait_until(s + 9);
        chk("f_count9", int'(cnt), 9);
        rst_n = 1'b0;
        @(negedge clk);
        chk("f_running", int'(running), 0);
        chk("f_tick", int'(tick), 0);
        chk("f_level", int'(level), 0);
        chk("f_clear", int'(bus.SC_SPEEDTICK_clear_OutLow), 0);
        chk("f_upcount", int'(bus.SC_SPEEDTICK_upcount_OutLow), 1);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
